image_sweep_ctrl: RTL and testbench
===================================

Name: image_sweep_ctrl

Overview:
Sequencer for the image pixel memory (Width x Height, ColorBits per pixel, one registered read port, one write port). On Start it raster-scans every pixel, reads it, applies a per-pixel operation and writes the result back, at one pixel per cycle. While idle it forwards host pixel writes to the memory write port. It sits between the processor control path and the image memory instance.

Parameters:
Width, 5, image columns; X coordinate range 0..Width-1.
Height, 10, image rows; Y coordinate range 0..Height-1.
ColorBits, 3, bits per pixel.

Ports:
clk  in  1  clock; all state changes on posedge.
rst  in  1  synchronous, active-high reset.
Start  in  1  begin a sweep; sampled only in IDLE.
Abort  in  1  stop the sweep early; sampled only in SWEEP.
Op  in  2  operation: 0 INVERT, 1 THRESHOLD, 2 FILL, 3 PASS; latched at Start.
Param  in  ColorBits  threshold or fill value; latched at Start.
Busy  out  1  high in SWEEP and DRAIN.
Done  out  1  one-cycle pulse at the end of a completed sweep.
HostWriteValid  in  1  host write request.
HostX / HostY / HostValue  in  9 / 8 / ColorBits  host write coordinate and data.
HostReady  out  1  high only in IDLE; a host write is accepted when HostWriteValid and HostReady are both high.
XRead / YRead  out  9 / 8  memory read address.
ReadValue  in  ColorBits  memory read data; valid on the cycle after the address is presented.
XWrite / YWrite / WriteValue  out  9 / 8 / ColorBits  memory write port.
MemWriteEn  out  1  qualifies the write port. The memory instance must gate its write with this signal.
Checksum  out  16  see Optional Feature.

Behaviour:
- Reset (rst high at an edge):
  - state returns to IDLE; x/y counters, stage-valid, latched Op/Param and Checksum clear to 0.
  - Busy=0, Done=0, XRead=YRead=0.
  - MemWriteEn is forced 0 combinationally during any cycle in which rst is high, so an in-flight pixel is dropped.
- States: IDLE, SWEEP, DRAIN, DONE.
  - IDLE -> SWEEP when Start=1; x=y=0 and Op/Param are latched.
  - SWEEP -> DRAIN after the cycle that issues (Width-1, Height-1).
  - SWEEP -> IDLE when Abort=1; no Done pulse.
  - DRAIN -> DONE, then DONE -> IDLE, each after exactly 1 cycle.
- Scan order and issue:
  - Row-major, X fastest: x increments to Width-1, wraps to 0, then y increments.
  - Each SWEEP cycle drives XRead/YRead = (x, y) and sets stage-valid with the coordinates registered.
- Write stage:
  - Driven combinationally on the following cycle: XWrite/YWrite = staged coordinates, WriteValue = f(ReadValue), MemWriteEn = stage-valid. The write commits at the end of that cycle.
  - INVERT: ~v. THRESHOLD: all-ones if v >= Param (unsigned), else 0. FILL: Param. PASS: v.
- Timing and throughput: 1 pixel/cycle. The first SWEEP cycle is cycle 1 after the Start-sampling edge; Done is high in cycle Width*Height+2.
- Abort:
  - Abort in a SWEEP cycle: that cycle's pixel is not staged; the pixel staged in the previous cycle is still written in the Abort cycle.
  - The next cycle is IDLE.
- Start/Abort while not in the sampling state: ignored.
- Host writes: in IDLE, MemWriteEn = HostWriteValid and the write port carries HostX/HostY/HostValue. Outside IDLE, host writes are not accepted and the host holds the request.
- Read port in IDLE: holds (0,0).
- No read/write hazards: every coordinate is visited once per sweep.

Optional Feature:
SWEEP_CHECKSUM_EN
- Defined: Checksum = sum mod 2^16 of all WriteValue words committed during the sweep. It clears at Start and is stable from DONE until the next Start.
- Undefined: Checksum is tied to 0 and no accumulator logic is built.

Decomposition:
- Package image_sweep_pkg:
  - op enum (INVERT/THRESHOLD/FILL/PASS) and state enum.
  - constants XADDR_W=9 and YADDR_W=8.
- One natural sub-module: sweep_pixel_op, the combinational f(v, Op, Param) unit.

Test Plan:
- Memory all 0; Start with Op=INVERT -> Busy for cycles 1-51, Done in cycle 52 only, all 50 pixels read back 7.
- Pixel(x,y) preloaded to (x+y) mod 8; THRESHOLD with Param=4 -> pixels with value >=4 become 7, others 0; (4,9) becomes 7, (1,2) becomes 0.
- Idle host write (2,3)=5 -> visible at the next read. Host write during SWEEP -> HostReady=0 and (2,3) unchanged by the host.
- FILL with Param=6, Abort high in cycle 10 -> pixels 0..8 (row-major) equal 6, pixel 9 onward unchanged, IDLE in cycle 11, no Done.
- rst high in cycle 20 of a sweep -> MemWriteEn=0 that cycle, IDLE next cycle with all outputs at reset values; a new Start restarts at (0,0).
- With SWEEP_CHECKSUM_EN, memory all 0, INVERT sweep -> Checksum=350 at Done; without the macro -> Checksum=0.

Source files
------------

// File: rtl/image_sweep_pkg.sv
// Shared types and address widths for the image sweep sequencer.
package image_sweep_pkg;

  localparam int XADDR_W = 9;
  localparam int YADDR_W = 8;

  typedef enum logic [1:0] {
    OP_INVERT    = 2'd0,
    OP_THRESHOLD = 2'd1,
    OP_FILL      = 2'd2,
    OP_PASS      = 2'd3
  } op_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SWEEP = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sweep_pixel_op.sv
// Per-pixel transform f(value, op, param); purely combinational.
module sweep_pixel_op
  import image_sweep_pkg::*;
#(
  parameter int ColorBits = 3
) (
  input  logic [ColorBits-1:0] value,
  input  op_t                  op,
  input  logic [ColorBits-1:0] param,
  output logic [ColorBits-1:0] result
);

  always_comb begin
    result = value;
    case (op)
      OP_INVERT:    result = ~value;
      OP_THRESHOLD: result = (value >= param) ? '1 : '0;
      OP_FILL:      result = param;
      default:      result = value;
    endcase
  end

endmodule

// File: rtl/image_sweep_ctrl.sv
// Raster read-modify-write sequencer for the image memory, one pixel per cycle.
// Optional running sum of written pixels is built only with SWEEP_CHECKSUM_EN.
module image_sweep_ctrl
  import image_sweep_pkg::*;
#(
  parameter int Width     = 5,
  parameter int Height    = 10,
  parameter int ColorBits = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Start,
  input  logic                 Abort,
  input  logic [1:0]           Op,
  input  logic [ColorBits-1:0] Param,
  output logic                 Busy,
  output logic                 Done,
  input  logic                 HostWriteValid,
  input  logic [XADDR_W-1:0]   HostX,
  input  logic [YADDR_W-1:0]   HostY,
  input  logic [ColorBits-1:0] HostValue,
  output logic                 HostReady,
  output logic [XADDR_W-1:0]   XRead,
  output logic [YADDR_W-1:0]   YRead,
  input  logic [ColorBits-1:0] ReadValue,
  output logic [XADDR_W-1:0]   XWrite,
  output logic [YADDR_W-1:0]   YWrite,
  output logic [ColorBits-1:0] WriteValue,
  output logic                 MemWriteEn,
  output logic [15:0]          Checksum
);

  localparam logic [XADDR_W-1:0] X_LAST = XADDR_W'(Width - 1);
  localparam logic [YADDR_W-1:0] Y_LAST = YADDR_W'(Height - 1);

  state_t                 state;
  logic [XADDR_W-1:0]     x;
  logic [YADDR_W-1:0]     y;
  logic                   stage_vld;
  logic [XADDR_W-1:0]     stage_x;
  logic [YADDR_W-1:0]     stage_y;
  op_t                    op_q;
  logic [ColorBits-1:0]   param_q;
  logic [ColorBits-1:0]   sweep_value;
  logic                   last_pixel;

  assign last_pixel = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      x         <= '0;
      y         <= '0;
      stage_vld <= 1'b0;
      stage_x   <= '0;
      stage_y   <= '0;
      op_q      <= OP_INVERT;
      param_q   <= '0;
    end else begin
      stage_vld <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state   <= ST_SWEEP;
            x       <= '0;
            y       <= '0;
            op_q    <= op_t'(Op);
            param_q <= Param;
          end
        end
        ST_SWEEP: begin
          // An aborted cycle stages nothing; the previous pixel still writes now.
          if (Abort) begin
            state <= ST_IDLE;
          end else begin
            stage_vld <= 1'b1;
            stage_x   <= x;
            stage_y   <= y;
            if (x == X_LAST) begin
              x <= '0;
              y <= last_pixel ? '0 : y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
            if (last_pixel) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  sweep_pixel_op #(.ColorBits(ColorBits)) u_pixel_op (
    .value  (ReadValue),
    .op     (op_q),
    .param  (param_q),
    .result (sweep_value)
  );

  assign Busy      = (state == ST_SWEEP) || (state == ST_DRAIN);
  assign Done      = (state == ST_DONE);
  assign HostReady = (state == ST_IDLE);
  assign XRead     = (state == ST_SWEEP) ? x : '0;
  assign YRead     = (state == ST_SWEEP) ? y : '0;

  // Reset kills the write combinationally so an in-flight pixel never lands.
  always_comb begin
    if (state == ST_IDLE) begin
      XWrite     = HostX;
      YWrite     = HostY;
      WriteValue = HostValue;
      MemWriteEn = HostWriteValid && !rst;
    end else begin
      XWrite     = stage_x;
      YWrite     = stage_y;
      WriteValue = sweep_value;
      MemWriteEn = stage_vld && !rst;
    end
  end

`ifdef SWEEP_CHECKSUM_EN
  logic [15:0] csum;

  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
    end else if ((state == ST_IDLE) && Start) begin
      csum <= '0;
    end else if (stage_vld) begin
      csum <= csum + 16'(sweep_value);
    end
  end

  assign Checksum = csum;
`else
  assign Checksum = '0;
`endif

endmodule

// File: tb/tb_image_sweep_ctrl.sv
// Directed bench for image_sweep_ctrl with a registered-read pixel memory model.
module tb_image_sweep_ctrl;
  import image_sweep_pkg::*;

  localparam int W = 5;
  localparam int H = 10;
  localparam int CB = 3;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               Start = 1'b0;
  logic               Abort = 1'b0;
  logic [1:0]         Op = 2'd0;
  logic [CB-1:0]      Param = '0;
  logic               Busy, Done, HostReady, MemWriteEn;
  logic               HostWriteValid = 1'b0;
  logic [XADDR_W-1:0] HostX = '0;
  logic [YADDR_W-1:0] HostY = '0;
  logic [CB-1:0]      HostValue = '0;
  logic [XADDR_W-1:0] XRead, XWrite;
  logic [YADDR_W-1:0] YRead, YWrite;
  logic [CB-1:0]      ReadValue, WriteValue;
  logic [15:0]        Checksum;

  int tests = 0;
  int fails = 0;

  image_sweep_ctrl #(.Width(W), .Height(H), .ColorBits(CB)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Abort(Abort), .Op(Op), .Param(Param),
    .Busy(Busy), .Done(Done), .HostWriteValid(HostWriteValid), .HostX(HostX),
    .HostY(HostY), .HostValue(HostValue), .HostReady(HostReady),
    .XRead(XRead), .YRead(YRead), .ReadValue(ReadValue),
    .XWrite(XWrite), .YWrite(YWrite), .WriteValue(WriteValue),
    .MemWriteEn(MemWriteEn), .Checksum(Checksum)
  );

  // Memory model: write gated by MemWriteEn, read data one cycle after address.
  logic [CB-1:0] mem [0:NPIX-1];
  logic [CB-1:0] rd_q = '0;
  logic          preload_req = 1'b0;
  int            preload_kind = 0;
  int            widx, ridx;

  assign widx = int'(YWrite) * W + int'(XWrite);
  assign ridx = int'(YRead) * W + int'(XRead);
  assign ReadValue = rd_q;

  function automatic logic [CB-1:0] pattern(input int kind, input int i);
    if (kind == 1) return CB'(((i % W) + (i / W)) % 8);
    if (kind == 2) return CB'(1);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < NPIX; i++) mem[i] <= pattern(preload_kind, i);
    end else if (MemWriteEn && widx < NPIX) begin
      mem[widx] <= WriteValue;
    end
    rd_q <= (ridx < NPIX) ? mem[ridx] : '0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int kind);
    next_cycle();
    preload_kind = kind;
    preload_req  = 1'b1;
    next_cycle();
    preload_req  = 1'b0;
  endtask

  // Leaves the bench 1ns into sweep cycle 1.
  task automatic start_sweep(input logic [1:0] op, input logic [CB-1:0] p);
    next_cycle();
    Start = 1'b1; Op = op; Param = p;
    next_cycle();
    Start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; HostWriteValid = 1'b1; HostX = 9'd1; HostY = 8'd1; HostValue = 3'd4;
    repeat (3) next_cycle();
    @(negedge clk);
    tests++; if (MemWriteEn !== 1'b0) begin fails++; $display("FAIL reset_wen_gated: got %0b want 0", MemWriteEn); end
    next_cycle();
    rst = 1'b0; HostWriteValid = 1'b0;
    @(negedge clk);
    tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", Busy); end
    tests++; if (Done !== 1'b0) begin fails++; $display("FAIL reset_done: got %0b want 0", Done); end
    tests++; if (HostReady !== 1'b1) begin fails++; $display("FAIL reset_hostready: got %0b want 1", HostReady); end
    tests++; if (XRead !== 9'd0 || YRead !== 8'd0) begin fails++; $display("FAIL reset_raddr: got (%0d,%0d) want (0,0)", XRead, YRead); end
    tests++; if (Checksum !== 16'd0) begin fails++; $display("FAIL reset_checksum: got %0d want 0", Checksum); end
  endtask

  task automatic test_invert();
    preload(0);
    start_sweep(OP_INVERT, 3'd0);
    for (int c = 1; c <= 53; c++) begin
      @(negedge clk);
      tests++; if (Busy !== 1'(c <= 51)) begin fails++; $display("FAIL invert_busy c%0d: got %0b want %0b", c, Busy, (c <= 51)); end
      tests++; if (Done !== 1'(c == 52)) begin fails++; $display("FAIL invert_done c%0d: got %0b want %0b", c, Done, (c == 52)); end
      if (c == 1) begin
        tests++; if (XRead !== 9'd0 || YRead !== 8'd0) begin fails++; $display("FAIL invert_first_raddr: got (%0d,%0d) want (0,0)", XRead, YRead); end
        tests++; if (MemWriteEn !== 1'b0) begin fails++; $display("FAIL invert_first_wen: got %0b want 0", MemWriteEn); end
      end
      if (c == 2) begin
        tests++; if (MemWriteEn !== 1'b1 || XWrite !== 9'd0 || YWrite !== 8'd0 || WriteValue !== 3'd7) begin
          fails++; $display("FAIL invert_first_write: got en=%0b (%0d,%0d)=%0d want en=1 (0,0)=7", MemWriteEn, XWrite, YWrite, WriteValue); end
      end
      if (c == 7) begin
        tests++; if (XRead !== 9'd1 || YRead !== 8'd1) begin fails++; $display("FAIL invert_raster: got (%0d,%0d) want (1,1)", XRead, YRead); end
      end
      if (c == 52) begin
`ifdef SWEEP_CHECKSUM_EN
        tests++; if (Checksum !== 16'd350) begin fails++; $display("FAIL invert_checksum: got %0d want 350", Checksum); end
`else
        tests++; if (Checksum !== 16'd0) begin fails++; $display("FAIL invert_checksum: got %0d want 0", Checksum); end
`endif
      end
      next_cycle();
    end
    for (int i = 0; i < NPIX; i++) begin
      tests++; if (mem[i] !== 3'd7) begin fails++; $display("FAIL invert_pixel %0d: got %0d want 7", i, mem[i]); end
    end
  endtask

  task automatic test_threshold();
    logic [CB-1:0] exp;
    preload(1);
    start_sweep(OP_THRESHOLD, 3'd4);
    repeat (53) next_cycle();
    for (int i = 0; i < NPIX; i++) begin
      exp = ((((i % W) + (i / W)) % 8) >= 4) ? 3'd7 : 3'd0;
      tests++; if (mem[i] !== exp) begin fails++; $display("FAIL threshold_pixel %0d: got %0d want %0d", i, mem[i], exp); end
    end
    tests++; if (mem[9*W+4] !== 3'd7) begin fails++; $display("FAIL threshold_4_9: got %0d want 7", mem[9*W+4]); end
    tests++; if (mem[2*W+1] !== 3'd0) begin fails++; $display("FAIL threshold_1_2: got %0d want 0", mem[2*W+1]); end
  endtask

  task automatic test_host_write();
    next_cycle();
    HostWriteValid = 1'b1; HostX = 9'd2; HostY = 8'd3; HostValue = 3'd5;
    @(negedge clk);
    tests++; if (HostReady !== 1'b1 || MemWriteEn !== 1'b1) begin fails++; $display("FAIL host_idle_accept: got rdy=%0b en=%0b want 1/1", HostReady, MemWriteEn); end
    tests++; if (XWrite !== 9'd2 || YWrite !== 8'd3 || WriteValue !== 3'd5) begin fails++; $display("FAIL host_idle_port: got (%0d,%0d)=%0d want (2,3)=5", XWrite, YWrite, WriteValue); end
    next_cycle();
    HostWriteValid = 1'b0;
    tests++; if (mem[17] !== 3'd5) begin fails++; $display("FAIL host_idle_commit: got %0d want 5", mem[17]); end
    start_sweep(OP_PASS, 3'd0);
    HostWriteValid = 1'b1; HostValue = 3'd1;
    for (int c = 1; c <= 53; c++) begin
      if (c == 52) HostWriteValid = 1'b0;
      @(negedge clk);
      if (c == 5) begin
        tests++; if (HostReady !== 1'b0) begin fails++; $display("FAIL host_sweep_ready: got %0b want 0", HostReady); end
      end
      if (c == 19) begin
        tests++; if (MemWriteEn !== 1'b1 || XWrite !== 9'd2 || YWrite !== 8'd3 || WriteValue !== 3'd5) begin
          fails++; $display("FAIL host_readback: got en=%0b (%0d,%0d)=%0d want en=1 (2,3)=5", MemWriteEn, XWrite, YWrite, WriteValue); end
      end
      next_cycle();
    end
    tests++; if (mem[17] !== 3'd5) begin fails++; $display("FAIL host_sweep_blocked: got %0d want 5", mem[17]); end
  endtask

  task automatic test_abort();
    logic [CB-1:0] exp;
    preload(2);
    start_sweep(OP_FILL, 3'd6);
    for (int c = 1; c <= 14; c++) begin
      Abort = (c == 10);
      @(negedge clk);
      tests++; if (Done !== 1'b0) begin fails++; $display("FAIL abort_no_done c%0d: got %0b want 0", c, Done); end
      if (c == 10) begin
        tests++; if (MemWriteEn !== 1'b1 || XWrite !== 9'd3 || YWrite !== 8'd1 || WriteValue !== 3'd6) begin
          fails++; $display("FAIL abort_last_write: got en=%0b (%0d,%0d)=%0d want en=1 (3,1)=6", MemWriteEn, XWrite, YWrite, WriteValue); end
      end
      if (c == 11) begin
        tests++; if (Busy !== 1'b0 || HostReady !== 1'b1 || MemWriteEn !== 1'b0) begin
          fails++; $display("FAIL abort_idle: got busy=%0b rdy=%0b en=%0b want 0/1/0", Busy, HostReady, MemWriteEn); end
      end
      next_cycle();
    end
    Abort = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      exp = (i < 9) ? 3'd6 : 3'd1;
      tests++; if (mem[i] !== exp) begin fails++; $display("FAIL abort_pixel %0d: got %0d want %0d", i, mem[i], exp); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    preload(0);
    start_sweep(OP_INVERT, 3'd0);
    for (int c = 1; c <= 20; c++) begin
      if (c == 20) rst = 1'b1;
      @(negedge clk);
      if (c == 20) begin
        tests++; if (MemWriteEn !== 1'b0) begin fails++; $display("FAIL rstmid_wen: got %0b want 0", MemWriteEn); end
      end
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (Busy !== 1'b0 || Done !== 1'b0 || HostReady !== 1'b1) begin
      fails++; $display("FAIL rstmid_state: got busy=%0b done=%0b rdy=%0b want 0/0/1", Busy, Done, HostReady); end
    tests++; if (XRead !== 9'd0 || YRead !== 8'd0 || MemWriteEn !== 1'b0 || Checksum !== 16'd0) begin
      fails++; $display("FAIL rstmid_outputs: got (%0d,%0d) en=%0b sum=%0d want (0,0) en=0 sum=0", XRead, YRead, MemWriteEn, Checksum); end
    tests++; if (mem[17] !== 3'd7) begin fails++; $display("FAIL rstmid_pixel17: got %0d want 7", mem[17]); end
    tests++; if (mem[18] !== 3'd0) begin fails++; $display("FAIL rstmid_pixel18_dropped: got %0d want 0", mem[18]); end
    start_sweep(OP_INVERT, 3'd0);
    @(negedge clk);
    tests++; if (XRead !== 9'd0 || YRead !== 8'd0 || Busy !== 1'b1) begin
      fails++; $display("FAIL rstmid_restart: got (%0d,%0d) busy=%0b want (0,0) busy=1", XRead, YRead, Busy); end
    repeat (53) next_cycle();
    tests++; if (mem[0] !== 3'd0) begin fails++; $display("FAIL rstmid_resweep_p0: got %0d want 0", mem[0]); end
    tests++; if (mem[18] !== 3'd7) begin fails++; $display("FAIL rstmid_resweep_p18: got %0d want 7", mem[18]); end
  endtask

  initial begin
    test_reset();
    test_invert();
    test_threshold();
    test_host_write();
    test_abort();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
